// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
package cache_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef logic [ARB_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache line transactions onto one memory port.
// One transaction in flight; strobes come from registers latched at grant, responses pass straight through.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    logic       last_grant_d;
    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    assign i_req   = i_pmem_read | i_pmem_write;
    assign d_req   = d_pmem_read | d_pmem_write;
    // On contention the client that was not served last wins.
    assign grant_i = i_req & (~d_req | last_grant_d);
    assign grant_d = d_req & ~grant_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= GRANT_I;
                        pmem_read    <= ~i_pmem_write;
                        pmem_write   <= i_pmem_write;
                        pmem_address <= i_pmem_address;
                        pmem_wdata   <= i_pmem_wdata;
                    end else if (grant_d) begin
                        state        <= GRANT_D;
                        pmem_read    <= ~d_pmem_write;
                        pmem_write   <= d_pmem_write;
                        pmem_address <= d_pmem_address;
                        pmem_wdata   <= d_pmem_wdata;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (pmem_resp) begin
                        state        <= RECOVER;
                        last_grant_d <= (state == GRANT_D);
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        pmem_wdata   <= '0;
                    end
                end
                // Gives the finished client a cycle to drop its request before re-arbitration.
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_pmem_resp  = (state == GRANT_I) & pmem_resp;
    assign d_pmem_resp  = (state == GRANT_D) & pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(i_pmem_read && i_pmem_write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then random traffic against a transaction model.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_pmem_read, i_pmem_write;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_wdata, i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read, d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata, d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Model: which client owns memory (0 none, 1 I, 2 D), what it latched, and who was served last.
    int           m_owner;
    bit           m_write;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    bit           m_cooldown;
    int           m_last;
    bit           i_seen, d_seen;
    int           served[$];
    int           i_count, d_count;

    localparam logic [127:0] A5_LINE   = {16{8'hA5}};
    localparam logic [127:0] BEEF_LINE = {4{32'hDEADBEEF}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_write    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_cooldown = 1'b0;
        m_last     = 1;
    endtask

    task automatic clear_inputs();
        i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
    endtask

    // Called just after a negedge with this cycle's inputs applied; compares, advances the model, waits a cycle.
    task automatic step();
        bit ir, dr, busy, done;
        #1;
        busy = (m_owner != 0);
        done = busy && pmem_resp;
        chk("pmem_read",  pmem_read,  busy && !m_write);
        chk("pmem_write", pmem_write, busy && m_write);
        chk("pmem_address", pmem_address, busy ? m_addr : 16'h0);
        chk("pmem_wdata", pmem_wdata, busy ? m_wdata : 128'h0);
        chk("i_resp",  i_pmem_resp,  done && m_owner == 1);
        chk("d_resp",  d_pmem_resp,  done && m_owner == 2);
        chk("i_rdata", i_pmem_rdata, (done && m_owner == 1) ? pmem_rdata : 128'h0);
        chk("d_rdata", d_pmem_rdata, (done && m_owner == 2) ? pmem_rdata : 128'h0);
        i_seen = i_pmem_resp;
        d_seen = d_pmem_resp;
        if (i_seen) begin served.push_back(1); i_count++; end
        if (d_seen) begin served.push_back(2); d_count++; end

        ir = i_pmem_read || i_pmem_write;
        dr = d_pmem_read || d_pmem_write;
        if (busy) begin
            if (pmem_resp) begin
                m_last = m_owner; m_owner = 0; m_cooldown = 1'b1;
            end
        end else if (m_cooldown) begin
            m_cooldown = 1'b0;
        end else if (ir || dr) begin
            if (ir && dr) m_owner = (m_last == 1) ? 2 : 1;
            else          m_owner = ir ? 1 : 2;
            if (m_owner == 1) begin
                m_write = i_pmem_write; m_addr = i_pmem_address; m_wdata = i_pmem_wdata;
            end else begin
                m_write = d_pmem_write; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int seen_i_gap;
        clear_inputs();
        model_reset();
        i_count = 0; d_count = 0;
        reset_n = 0;
        #2;
        chk("reset_read",  pmem_read, 0);
        chk("reset_write", pmem_write, 0);
        chk("reset_addr",  pmem_address, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        step();

        // Lone D read, memory answers on the third strobe cycle.
        d_pmem_read = 1; d_pmem_address = 16'h1230;
        step();
        #1 chk("dread_strobe_n1", pmem_read, 1);
        chk("dread_addr", pmem_address, 16'h1230);
        step();
        step();
        pmem_resp = 1; pmem_rdata = A5_LINE;
        #1 chk("dread_resp", d_pmem_resp, 1);
        chk("dread_rdata", d_pmem_rdata, A5_LINE);
        chk("dread_iresp", i_pmem_resp, 0);
        step();
        pmem_resp = 0; pmem_rdata = '0; d_pmem_read = 0;
        #1 chk("dread_strobe_drop", pmem_read, 0);
        step();
        step();

        // Stray response while idle.
        pmem_resp = 1; pmem_rdata = A5_LINE;
        #1 chk("stray_iresp", i_pmem_resp, 0);
        chk("stray_dresp", d_pmem_resp, 0);
        chk("stray_drdata", d_pmem_rdata, 0);
        step();
        pmem_resp = 0; pmem_rdata = '0;
        step();

        // Reset so last grant is I, then both clients request together: D goes first.
        reset_n = 0; model_reset();
        @(negedge clk);
        reset_n = 1;
        step();
        i_pmem_read = 1; i_pmem_address = 16'h0040;
        d_pmem_write = 1; d_pmem_address = 16'h2000; d_pmem_wdata = A5_LINE;
        step();
        #1 chk("both_first_write", pmem_write, 1);
        chk("both_first_addr", pmem_address, 16'h2000);
        pmem_resp = 1;
        step();
        pmem_resp = 0; d_pmem_write = 0;
        step();
        step();
        #1 chk("both_second_read", pmem_read, 1);
        chk("both_second_addr", pmem_address, 16'h0040);
        pmem_resp = 1; pmem_rdata = BEEF_LINE;
        step();
        pmem_resp = 0; pmem_rdata = '0; i_pmem_read = 0;
        step();
        step();

        // D writeback; inputs scrambled after grant must not leak to memory.
        d_pmem_write = 1; d_pmem_address = 16'h3FF0; d_pmem_wdata = BEEF_LINE;
        step();
        d_pmem_address = 16'h1111; d_pmem_wdata = A5_LINE;
        #1 chk("wb_write", pmem_write, 1);
        chk("wb_read", pmem_read, 0);
        step();
        #1 chk("wb_addr_hold", pmem_address, 16'h3FF0);
        chk("wb_wdata_hold", pmem_wdata, BEEF_LINE);
        pmem_resp = 1;
        step();
        pmem_resp = 0; d_pmem_write = 0;
        step();
        step();

        // Reset during an I read abandons it.
        i_pmem_read = 1; i_pmem_address = 16'h0abc;
        step();
        step();
        reset_n = 0;
        #1 chk("rst_mid_read", pmem_read, 0);
        chk("rst_mid_iresp", i_pmem_resp, 0);
        model_reset();
        i_pmem_read = 0;
        @(negedge clk);
        reset_n = 1;
        step();
        step();

        // Both requesting continuously: grants alternate D, I, D, I.
        served.delete();
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h0200;
        for (int c = 0; c < 60 && served.size() < 4; c++) begin
            pmem_resp = pmem_read;
            pmem_rdata = {8{c[15:0]}};
            step();
        end
        pmem_resp = 0;
        i_pmem_read = 0; d_pmem_read = 0;
        chk("alt_count", served.size(), 4);
        if (served.size() >= 4) begin
            chk("alt_0", served[0], 2);
            chk("alt_1", served[1], 1);
            chk("alt_2", served[2], 2);
            chk("alt_3", served[3], 1);
        end
        step();
        step();

        // Random traffic against the model.
        i_count = 0; d_count = 0;
        i_seen = 0; d_seen = 0;
        seen_i_gap = 0;
        for (int c = 0; c < 3000; c++) begin
            pmem_resp  = ($urandom_range(0, 2) == 0);
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (i_seen || (!i_pmem_read && !i_pmem_write && $urandom_range(0, 1) == 0)
                || ((i_pmem_read || i_pmem_write) && $urandom_range(0, 31) == 0)) begin
                if (i_seen || i_pmem_read || i_pmem_write) begin
                    i_pmem_read = 0; i_pmem_write = 0;
                end else begin
                    i_pmem_write = $urandom_range(0, 1);
                    i_pmem_read  = ~i_pmem_write;
                end
            end
            if (d_seen || (!d_pmem_read && !d_pmem_write && $urandom_range(0, 1) == 0)
                || ((d_pmem_read || d_pmem_write) && $urandom_range(0, 31) == 0)) begin
                if (d_seen || d_pmem_read || d_pmem_write) begin
                    d_pmem_read = 0; d_pmem_write = 0;
                end else begin
                    d_pmem_write = $urandom_range(0, 1);
                    d_pmem_read  = ~d_pmem_write;
                end
            end
            i_pmem_address = $urandom; i_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            d_pmem_address = $urandom; d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            if (c == 1500) begin
                // Occasional async reset in the middle of random traffic.
                reset_n = 0;
                #1 chk("rand_rst_read", pmem_read | pmem_write, 0);
                model_reset();
                @(negedge clk);
                reset_n = 1;
            end
            step();
        end
        clear_inputs();
        step();
        step();
        chk("rand_i_served", i_count > 10, 1);
        chk("rand_d_served", d_count > 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
